// File: rtl/echo_window_detector_if.sv
// Signal bundle between the echo window detector and its ping controller / ranging logic.
// The slave modport is the detector's view; the master modport is the driver's view.
interface echo_window_detector_if #(
    parameter int SAMPLE_WIDTH = 12
);
    logic                    emit_start_in;
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid_in;
    logic [SAMPLE_WIDTH-1:0] threshold_in;
    logic [31:0]             time_since_emission;
    logic                    echo_detected;
    logic [31:0]             echo_time_out;
    logic                    timeout_out;
    logic                    busy_out;

    modport slave (
        input  emit_start_in, sample_in, sample_valid_in, threshold_in,
        output time_since_emission, echo_detected, echo_time_out, timeout_out, busy_out
    );

    modport master (
        output emit_start_in, sample_in, sample_valid_in, threshold_in,
        input  time_since_emission, echo_detected, echo_time_out, timeout_out, busy_out
    );
endinterface

// File: rtl/echo_window_detector.sv
// Per-ping timebase with blanking, run-length echo confirmation and listen-window timeout.
// Emits a one-cycle echo pulse with the run-start timestamp, or a one-cycle timeout pulse.
module echo_window_detector #(
    parameter int SAMPLE_WIDTH    = 12,
    parameter int BLANK_CYCLES    = 20000,
    parameter int MAX_TIME_WINDOW = 500000,
    parameter int CONFIRM_COUNT   = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    echo_window_detector_if.slave bus
);
    localparam int RUN_W = $clog2(CONFIRM_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_LISTEN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [31:0]      run_start_q, run_start_d;
    logic             echo_q, echo_d;
    logic [31:0]      echo_time_q, echo_time_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic             qualify;
    logic             confirm;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_q       <= '0;
            run_start_q <= '0;
            echo_q      <= 1'b0;
            echo_time_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            run_start_q <= run_start_d;
            echo_q      <= echo_d;
            echo_time_q <= echo_time_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        run_start_d = run_start_q;
        echo_d      = 1'b0;
        echo_time_d = echo_time_q;
        timeout_d   = 1'b0;

        qualify = (state_q == ST_LISTEN) && bus.sample_valid_in
                  && (bus.sample_in >= bus.threshold_in);
        confirm = qualify && (run_q == RUN_W'(CONFIRM_COUNT - 1));

        // A restart overrides any confirm or timeout landing on the same cycle.
        if (bus.emit_start_in) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            run_d   = '0;
        end else if (state_q != ST_IDLE) begin
            cnt_d = cnt_q + 32'd1;

            if (state_q == ST_BLANK && cnt_q == 32'(BLANK_CYCLES - 1)) begin
                state_d = ST_LISTEN;
            end

            if (state_q == ST_LISTEN && bus.sample_valid_in) begin
                if (qualify) begin
                    if (run_q == '0) begin
                        run_start_d = cnt_q;
                    end
                    if (confirm) begin
                        echo_d      = 1'b1;
                        echo_time_d = (run_q == '0) ? cnt_q : run_start_q;
                        state_d     = ST_IDLE;
                        run_d       = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else begin
                    run_d = '0;
                end
            end

            if (!confirm && cnt_q == 32'(MAX_TIME_WINDOW - 1)) begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
                run_d     = '0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.time_since_emission = cnt_q;
    assign bus.echo_detected       = echo_q;
    assign bus.echo_time_out       = echo_time_q;
    assign bus.timeout_out         = timeout_q;
    assign bus.busy_out            = busy_q;

endmodule

// File: tb/tb_echo_window_detector.sv
// Scoreboard bench for echo_window_detector: a ping-level reference model queues expected
// pulses while a negedge monitor pops and compares whenever the DUT pulses.
module tb_echo_window_detector;
    localparam int SW    = 12;
    localparam int BLANK = 10;
    localparam int MAXW  = 100;
    localparam int CONF  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    echo_window_detector_if #(.SAMPLE_WIDTH(SW)) bus ();

    echo_window_detector #(
        .SAMPLE_WIDTH   (SW),
        .BLANK_CYCLES   (BLANK),
        .MAX_TIME_WINDOW(MAXW),
        .CONFIRM_COUNT  (CONF)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    typedef struct {
        bit          is_echo;
        int unsigned etime;
        int unsigned tse;
    } ev_t;

    ev_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: ping-level view with the current run kept as a list of timestamps.
    bit          m_active = 1'b0;
    int unsigned m_t      = 0;
    int unsigned m_run[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit e, input int s, input bit v, input int thr, input bit r);
        ev_t ev;
        bit  fired;
        rst                 = r;
        bus.emit_start_in   = e;
        bus.sample_in       = SW'(s);
        bus.sample_valid_in = v;
        bus.threshold_in    = SW'(thr);

        if (r) begin
            m_active = 1'b0;
            m_t      = 0;
            m_run.delete();
        end else if (e) begin
            m_active = 1'b1;
            m_t      = 0;
            m_run.delete();
        end else if (m_active) begin
            fired = 1'b0;
            if (m_t >= BLANK && v) begin
                if (s >= thr) begin
                    m_run.push_back(m_t);
                    if (m_run.size() == CONF) begin
                        ev.is_echo = 1'b1;
                        ev.etime   = m_run[0];
                        ev.tse     = m_t + 1;
                        exp_q.push_back(ev);
                        m_active = 1'b0;
                        fired    = 1'b1;
                        m_run.delete();
                    end
                end else begin
                    m_run.delete();
                end
            end
            if (!fired && m_t == MAXW - 1) begin
                ev.is_echo = 1'b0;
                ev.etime   = 0;
                ev.tse     = MAXW;
                exp_q.push_back(ev);
                m_active = 1'b0;
                m_run.delete();
            end
            m_t = m_t + 1;
        end

        @(posedge clk);
        #1;
        check("time_since_emission", bus.time_since_emission, m_t);
        check("busy_out", bus.busy_out, m_active);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 500, 1'b0);
    endtask

    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            check("pulse_exclusive", bus.echo_detected & bus.timeout_out, 0);
            if (bus.echo_detected || bus.timeout_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_queue", exp_q.size(), 1);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_is_echo", bus.echo_detected, ev.is_echo);
                    check("pulse_time_since_emission", bus.time_since_emission, ev.tse);
                    if (ev.is_echo) check("echo_time_out", bus.echo_time_out, ev.etime);
                    $display("pulse %s tse=%0d echo_time=%0d", ev.is_echo ? "echo" : "timeout",
                             bus.time_since_emission, bus.echo_time_out);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.emit_start_in   = 1'b0;
        bus.sample_in       = '0;
        bus.sample_valid_in = 1'b0;
        bus.threshold_in    = SW'(500);

        // Reset then quiet idle
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0, 500, 1'b1);
        idle(20);
        check("idle_echo_detected", bus.echo_detected, 0);
        check("idle_timeout_out", bus.timeout_out, 0);
        check("idle_echo_time_out", bus.echo_time_out, 0);

        // Continuous strong samples: blanking ignores 0-9, echo at 10
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        guard = 0;
        while (m_active && guard < 200) begin
            drive(1'b0, 900, 1'b1, 500, 1'b0);
            guard++;
        end
        idle(3);
        check("t2_echo_time_out", bus.echo_time_out, 10);

        // Run broken at 22, re-forms at 23
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        guard = 0;
        while (m_active && guard < 200) begin
            case (m_t)
                20: drive(1'b0, 600, 1'b1, 500, 1'b0);
                21: drive(1'b0, 700, 1'b1, 500, 1'b0);
                22: drive(1'b0, 300, 1'b1, 500, 1'b0);
                23, 24, 25: drive(1'b0, 600, 1'b1, 500, 1'b0);
                default: drive(1'b0, 900, 1'b0, 500, 1'b0);
            endcase
            guard++;
        end
        idle(2);
        check("t3_echo_time_out", bus.echo_time_out, 23);

        // Sparse valid strobes: gaps do not break the run
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        guard = 0;
        while (m_active && guard < 200) begin
            if (m_t == 30 || m_t == 40 || m_t == 50) drive(1'b0, 501, 1'b1, 500, 1'b0);
            else drive(1'b0, 900, 1'b0, 500, 1'b0);
            guard++;
        end
        idle(2);
        check("t4_echo_time_out", bus.echo_time_out, 30);

        // All sub-threshold: timeout, counter saturates at window
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        guard = 0;
        while (m_active && guard < 200) begin
            drive(1'b0, 499, 1'b1, 500, 1'b0);
            guard++;
        end
        idle(5);
        check("timeout_tse_held", bus.time_since_emission, MAXW);
        check("echo_time_held", bus.echo_time_out, 30);

        // Confirm on the last window cycle beats timeout
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        guard = 0;
        while (m_active && guard < 200) begin
            if (m_t >= 97) drive(1'b0, 900, 1'b1, 500, 1'b0);
            else drive(1'b0, 0, 1'b0, 500, 1'b0);
            guard++;
        end
        idle(2);
        check("boundary_echo_time_out", bus.echo_time_out, 97);

        // Restart mid-ping, then reset mid-ping
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        while (m_t < 50) drive(1'b0, 0, 1'b0, 500, 1'b0);
        drive(1'b1, 0, 1'b0, 500, 1'b0);
        check("restart_counter", bus.time_since_emission, 0);
        while (m_t < 60) drive(1'b0, 0, 1'b0, 500, 1'b0);
        drive(1'b0, 0, 1'b0, 500, 1'b1);
        check("reset_tse", bus.time_since_emission, 0);
        check("reset_echo_time_out", bus.echo_time_out, 0);
        check("reset_busy", bus.busy_out, 0);
        check("reset_echo", bus.echo_detected, 0);
        check("reset_timeout", bus.timeout_out, 0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(59) == 0, int'($urandom_range(700, 300)),
                  $urandom_range(1) == 1, int'($urandom_range(600, 400)),
                  $urandom_range(999) == 0);
        end
        idle(MAXW + 5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/echo_window_detector.md
Name: echo_window_detector

Overview:
- Upstream stage of the time-of-flight ranging block; owns the per-ping timebase and decides when a valid echo has arrived.
- On each emission start it runs a cycle counter, exported as time_since_emission.
- It ignores receiver samples during a blanking window, which masks transducer ring-down.
- It then confirms an echo only after CONFIRM_COUNT consecutive valid samples at or above a threshold, and issues either a one-cycle echo pulse with a timestamp or a timeout pulse.

Parameters:
- SAMPLE_WIDTH, 12: receiver magnitude sample width.
- BLANK_CYCLES, 20000: cycles after emission during which samples are ignored. Must be >= 1 and < MAX_TIME_WINDOW.
- MAX_TIME_WINDOW, 500000: listen window in clk_in cycles (5 ms at 100 MHz).
- CONFIRM_COUNT, 4: consecutive above-threshold valid samples required. Must be >= 1.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  synchronous, active-high reset
- emit_start_in  input  1  one-cycle pulse marking transmit burst start
- sample_in  input  SAMPLE_WIDTH  unsigned receiver magnitude
- sample_valid_in  input  1  sample_in qualifier
- threshold_in  input  SAMPLE_WIDTH  unsigned detection threshold; sampled every cycle
- time_since_emission  output  32  cycles since emission start
- echo_detected  output  1  one-cycle pulse, echo confirmed
- echo_time_out  output  32  counter value at the first sample of the confirming run; valid from the echo_detected cycle, held until next confirm
- timeout_out  output  1  one-cycle pulse, window expired with no echo
- busy_out  output  1  high in BLANK or LISTEN

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset: state=IDLE. All of the following are 0: time_since_emission, echo_detected, echo_time_out, timeout_out, busy_out, run counter, run-start register.
- States: IDLE, BLANK, LISTEN.
- IDLE:
  - Counter holds its last value.
  - When emit_start_in=1: next cycle state=BLANK, counter=0, run counter=0.
- BLANK and LISTEN:
  - Counter increments by 1 every cycle.
  - busy_out=1, registered to match the state.
- BLANK:
  - Samples are ignored.
  - When counter==BLANK_CYCLES-1: next state=LISTEN, counter=BLANK_CYCLES.
- LISTEN, on a cycle with sample_valid_in=1:
  - If sample_in >= threshold_in: run counter increments.
  - If this is the first sample of the run (run counter was 0), the current counter value is captured into the run-start register.
  - If sample_in < threshold_in: run counter clears to 0.
- LISTEN, on a cycle with sample_valid_in=0: run counter holds. Gaps between valid samples do not break a run.
- Confirm: when a qualifying sample brings the run count to CONFIRM_COUNT, the next cycle has:
  - echo_detected=1;
  - echo_time_out = run-start value (the counter at the run's first sample, or the current counter if CONFIRM_COUNT=1);
  - state=IDLE;
  - counter holding the value it took that cycle.
- Timeout: in BLANK or LISTEN, when counter==MAX_TIME_WINDOW-1 and no confirm occurs that cycle, the next cycle has:
  - timeout_out=1;
  - counter=MAX_TIME_WINDOW, then held;
  - state=IDLE.
  This guarantees a downstream comparison counter >= MAX_TIME_WINDOW fires.
- Confirm and timeout in the same cycle: confirm wins; timeout_out stays 0.
- emit_start_in while busy: the ping restarts. Next cycle state=BLANK, counter=0, run counter=0. No echo or timeout pulse is issued for the aborted ping.
- emit_start_in coincident with a confirm or timeout cycle: the restart wins, and neither pulse is issued.
- Pulses: echo_detected and timeout_out are never high together, and each is high for exactly one cycle.
- Reset mid-ping: returns to the reset state on the next edge; no pulses are issued.
- Arithmetic:
  - Counter is 32-bit unsigned and cannot wrap, because it saturates via timeout.
  - Threshold compare is unsigned and inclusive.
  - Run counter width is $clog2(CONFIRM_COUNT+1).

Test Plan (BLANK_CYCLES=10, MAX_TIME_WINDOW=100, CONFIRM_COUNT=3, SAMPLE_WIDTH=12, threshold_in=500):
- Reset, then idle 20 cycles -> all outputs 0.
- emit_start pulse; samples of 900 valid every cycle from counter 0 -> samples at counter 0-9 ignored. Samples at counter 10, 11, 12 qualify. echo_detected pulses on the cycle after counter 12 with echo_time_out=10; busy_out then drops.
- emit_start; valid samples at counter 20=600, 21=700, 22=300, 23=600, 24=600, 25=600 -> the run breaks at 22. Echo fires after the sample at 25 with echo_time_out=23.
- emit_start; valid sample=501 only at counter 30, 40, 50, with no valid strobe in between -> echo confirmed after counter 50, echo_time_out=30. Then, with all samples=499: one pulse of timeout_out, time_since_emission=100 and held, echo_detected stays 0.
- Boundary: qualifying samples at counter 97, 98, 99 -> echo_detected=1 and timeout_out=0 on the same following cycle.
- emit_start at counter 50 of an active ping -> counter restarts at 0 with no pulse. Separately, rst_in asserted at counter 60 -> next cycle all outputs 0 and state IDLE.
